// File: rtl/morse_decoder.sv
// Purpose : decodes a hand-keyed Morse signal into ASCII letters, digits and word spaces.
// Latency : a letter is emitted 2 units (+2 sync cycles) after its last mark ends; a space 5 units after it.
// Backpres: none; the key cannot be throttled, so output pulses are single-cycle and never stalled.
//
// Ports:
//   clk_24      sole clock, rising edge
//   rst         synchronous reset, active-high
//   key_in      asynchronous key level (1 = tone)
//   ascii_out   last decoded character (A-Z, 0-9, or 32 for a word gap)
//   ascii_valid one-cycle pulse when ascii_out is new
//   error       one-cycle pulse when an element sequence cannot be decoded
module morse_decoder #(
    parameter int UNIT_TICKS = 2400000,
    parameter int MIN_TICKS  = 240000,
    parameter int CNT_W      = 25
) (
    input  logic       clk_24,
    input  logic       rst,
    input  logic       key_in,
    output logic [6:0] ascii_out,
    output logic       ascii_valid,
    output logic       error
);

    localparam logic [CNT_W-1:0] SAT_T    = CNT_W'(7 * UNIT_TICKS);
    localparam logic [CNT_W-1:0] LETTER_T = CNT_W'(2 * UNIT_TICKS);
    localparam logic [CNT_W-1:0] WORD_T   = CNT_W'(5 * UNIT_TICKS);
    localparam logic [CNT_W-1:0] DASH_T   = CNT_W'(2 * UNIT_TICKS);
    localparam logic [CNT_W-1:0] MIN_T    = CNT_W'(MIN_TICKS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MARK = 2'd1,
        GAP  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Synchronizer and rising-edge qualification
    // ------------------------------------------------------------------
    logic       key_m;
    logic       key_s;
    logic       key_d;
    logic [1:0] settle;
    logic       armed;
    logic       rise;

    // key_s is only trustworthy two edges after reset; a key already held
    // down at that point must be seen low once before any mark may start.
    always_ff @(posedge clk_24) begin
        if (rst) begin
            key_m  <= 1'b0;
            key_s  <= 1'b0;
            key_d  <= 1'b0;
            settle <= 2'd0;
            armed  <= 1'b0;
        end else begin
            key_m  <= key_in;
            key_s  <= key_m;
            key_d  <= key_s;
            if (settle != 2'd2) begin
                settle <= settle + 2'd1;
            end
            if (settle == 2'd2 && !key_s) begin
                armed <= 1'b1;
            end
        end
    end

    assign rise = armed & key_s & ~key_d;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v >= SAT_T) ? SAT_T : v + CNT_W'(1);
    endfunction

    // Returns {hit, ascii}. Element i sits in bit i, 1 = dash; unused upper
    // pattern bits are always zero because the pattern is cleared per letter.
    function automatic logic [7:0] decode(input logic [2:0] cnt, input logic [4:0] pat);
        logic [7:0] r;
        r = 8'd0;
        case ({cnt, pat})
            {3'd2, 5'd2 }: r = {1'b1, 7'h41}; // A .-
            {3'd4, 5'd1 }: r = {1'b1, 7'h42}; // B -...
            {3'd4, 5'd5 }: r = {1'b1, 7'h43}; // C -.-.
            {3'd3, 5'd1 }: r = {1'b1, 7'h44}; // D -..
            {3'd1, 5'd0 }: r = {1'b1, 7'h45}; // E .
            {3'd4, 5'd4 }: r = {1'b1, 7'h46}; // F ..-.
            {3'd3, 5'd3 }: r = {1'b1, 7'h47}; // G --.
            {3'd4, 5'd0 }: r = {1'b1, 7'h48}; // H ....
            {3'd2, 5'd0 }: r = {1'b1, 7'h49}; // I ..
            {3'd4, 5'd14}: r = {1'b1, 7'h4A}; // J .---
            {3'd3, 5'd5 }: r = {1'b1, 7'h4B}; // K -.-
            {3'd4, 5'd2 }: r = {1'b1, 7'h4C}; // L .-..
            {3'd2, 5'd3 }: r = {1'b1, 7'h4D}; // M --
            {3'd2, 5'd1 }: r = {1'b1, 7'h4E}; // N -.
            {3'd3, 5'd7 }: r = {1'b1, 7'h4F}; // O ---
            {3'd4, 5'd6 }: r = {1'b1, 7'h50}; // P .--.
            {3'd4, 5'd11}: r = {1'b1, 7'h51}; // Q --.-
            {3'd3, 5'd2 }: r = {1'b1, 7'h52}; // R .-.
            {3'd3, 5'd0 }: r = {1'b1, 7'h53}; // S ...
            {3'd1, 5'd1 }: r = {1'b1, 7'h54}; // T -
            {3'd3, 5'd4 }: r = {1'b1, 7'h55}; // U ..-
            {3'd4, 5'd8 }: r = {1'b1, 7'h56}; // V ...-
            {3'd3, 5'd6 }: r = {1'b1, 7'h57}; // W .--
            {3'd4, 5'd9 }: r = {1'b1, 7'h58}; // X -..-
            {3'd4, 5'd13}: r = {1'b1, 7'h59}; // Y -.--
            {3'd4, 5'd3 }: r = {1'b1, 7'h5A}; // Z --..
            {3'd5, 5'd31}: r = {1'b1, 7'h30}; // 0 -----
            {3'd5, 5'd30}: r = {1'b1, 7'h31}; // 1 .----
            {3'd5, 5'd28}: r = {1'b1, 7'h32}; // 2 ..---
            {3'd5, 5'd24}: r = {1'b1, 7'h33}; // 3 ...--
            {3'd5, 5'd16}: r = {1'b1, 7'h34}; // 4 ....-
            {3'd5, 5'd0 }: r = {1'b1, 7'h35}; // 5 .....
            {3'd5, 5'd1 }: r = {1'b1, 7'h36}; // 6 -....
            {3'd5, 5'd3 }: r = {1'b1, 7'h37}; // 7 --...
            {3'd5, 5'd7 }: r = {1'b1, 7'h38}; // 8 ---..
            {3'd5, 5'd15}: r = {1'b1, 7'h39}; // 9 ----.
            default:       r = 8'd0;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // FSM state
    // ------------------------------------------------------------------
    state_t           state,      state_n;
    logic             ret_gap,    ret_gap_n;    // state to resume after a glitch
    logic [4:0]       pattern,    pattern_n;
    logic [2:0]       count,      count_n;
    logic             ovf,        ovf_n;
    logic [CNT_W-1:0] mark_cnt,   mark_cnt_n;
    logic [CNT_W-1:0] gap_cnt,    gap_cnt_n;
    logic             space_pend, space_pend_n;
    logic [6:0]       ascii_out_n;
    logic             valid_n;
    logic             err_n;

    always_ff @(posedge clk_24) begin
        if (rst) begin
            state       <= IDLE;
            ret_gap     <= 1'b0;
            pattern     <= '0;
            count       <= '0;
            ovf         <= 1'b0;
            mark_cnt    <= '0;
            gap_cnt     <= '0;
            space_pend  <= 1'b0;
            ascii_out   <= '0;
            ascii_valid <= 1'b0;
            error       <= 1'b0;
        end else begin
            state       <= state_n;
            ret_gap     <= ret_gap_n;
            pattern     <= pattern_n;
            count       <= count_n;
            ovf         <= ovf_n;
            mark_cnt    <= mark_cnt_n;
            gap_cnt     <= gap_cnt_n;
            space_pend  <= space_pend_n;
            ascii_out   <= ascii_out_n;
            ascii_valid <= valid_n;
            error       <= err_n;
        end
    end

    logic             silent;    // this cycle is a silence cycle for gap timing
    logic [CNT_W-1:0] gap_base;  // gap value before this cycle's increment
    logic [7:0]       dec;

    always_comb begin
        state_n      = state;
        ret_gap_n    = ret_gap;
        pattern_n    = pattern;
        count_n      = count;
        ovf_n        = ovf;
        mark_cnt_n   = mark_cnt;
        gap_cnt_n    = gap_cnt;
        space_pend_n = space_pend;
        ascii_out_n  = ascii_out;
        valid_n      = 1'b0;
        err_n        = 1'b0;
        silent       = 1'b0;
        gap_base     = gap_cnt;
        dec          = 8'd0;

        case (state)
            MARK: begin
                if (key_s) begin
                    mark_cnt_n = sat_inc(mark_cnt);
                end else begin
                    // Falling edge: classify the mark, then treat this
                    // cycle as the first silence cycle.
                    silent = 1'b1;
                    if (mark_cnt < MIN_T) begin
                        state_n = ret_gap ? GAP : IDLE;
                    end else begin
                        state_n  = GAP;
                        gap_base = '0;
                        if (count == 3'd5) begin
                            ovf_n = 1'b1;
                        end else begin
                            pattern_n = pattern | (5'(mark_cnt >= DASH_T) << count);
                            count_n   = count + 3'd1;
                        end
                    end
                end
            end
            default: begin
                if (rise) begin
                    state_n      = MARK;
                    ret_gap_n    = (state == GAP);
                    mark_cnt_n   = CNT_W'(1);
                    space_pend_n = 1'b0;
                end else begin
                    silent = 1'b1;
                end
            end
        endcase

        if (silent) begin
            gap_cnt_n = sat_inc(gap_base);
            if (state_n == GAP && gap_cnt_n == LETTER_T) begin
                dec = decode(count_n, pattern_n);
                if (dec[7] && !ovf_n) begin
                    ascii_out_n = dec[6:0];
                    valid_n     = 1'b1;
                end else begin
                    err_n = 1'b1;
                end
                pattern_n    = '0;
                count_n      = '0;
                ovf_n        = 1'b0;
                state_n      = IDLE;
                space_pend_n = 1'b1;
            end else if (state_n == IDLE && space_pend && gap_cnt_n == WORD_T) begin
                ascii_out_n  = 7'd32;
                valid_n      = 1'b1;
                space_pend_n = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_morse_decoder.sv
module tb_morse_decoder;

    localparam int UT = 10;
    localparam int MT = 3;

    logic       clk_24 = 1'b0;
    logic       rst    = 1'b1;
    logic       key_in = 1'b0;
    logic [6:0] ascii_out;
    logic       ascii_valid;
    logic       error;

    morse_decoder #(.UNIT_TICKS(UT), .MIN_TICKS(MT), .CNT_W(8)) dut (
        .clk_24      (clk_24),
        .rst         (rst),
        .key_in      (key_in),
        .ascii_out   (ascii_out),
        .ascii_valid (ascii_valid),
        .error       (error)
    );

    always #5 clk_24 = ~clk_24;

    int cyc = 0;
    always @(posedge clk_24) cyc <= cyc + 1;

    typedef struct {
        int kind;   // 0 = character, 1 = error
        int ch;
        int at;     // cycle stamp, -1 = not timed
    } ev_t;

    ev_t obs_q[$];
    ev_t exp_q[$];
    int  both_cnt = 0;

    always @(negedge clk_24) begin
        if (ascii_valid && error) both_cnt++;
        if (ascii_valid)  obs_q.push_back('{0, int'(ascii_out), cyc});
        else if (error)   obs_q.push_back('{1, 0, cyc});
    end

    int checks   = 0;
    int failures = 0;
    int last_ch  = 0;

    string morse_tab [36] = '{
        ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
        "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
        "..-", "...-", ".--", "-..-", "-.--", "--..",
        "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
        "---..", "----."
    };
    string chars = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";

    function automatic int lookup(string code);
        for (int i = 0; i < 36; i++)
            if (morse_tab[i] == code) return int'(chars[i]);
        return -1;
    endfunction

    function automatic string rand_code();
        string s;
        int    n;
        s = "";
        if ($urandom_range(0, 3) == 0) begin
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 1) == 1) s = {s, "-"};
                else                           s = {s, "."};
            end
        end else begin
            s = morse_tab[$urandom_range(0, 35)];
        end
        return s;
    endfunction

    task automatic chk(string tag, int got, int want);
        checks++;
        assert (got === want) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
        end
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk_24);
            #1;
        end
    endtask

    task automatic mark(int n);
        key_in = 1'b1;
        tick(n);
        key_in = 1'b0;
    endtask

    task automatic quiet(int n);
        key_in = 1'b0;
        tick(n);
    endtask

    task automatic expect_ev(int kind, int ch, int at);
        exp_q.push_back('{kind, ch, at});
    endtask

    // Drives one code with random element and inter-element timing, and
    // records what the decoder must produce for it.
    task automatic send_code(string code);
        int r;
        for (int i = 0; i < code.len(); i++) begin
            if (code[i] == "-") mark($urandom_range(22, 45));
            else                mark($urandom_range(4, 15));
            if (i < code.len() - 1) quiet($urandom_range(4, 15));
        end
        r = lookup(code);
        if (r < 0) begin
            expect_ev(1, 0, -1);
        end else begin
            expect_ev(0, r, -1);
            last_ch = r;
        end
    endtask

    task automatic check_events(string tag);
        chk({tag, "_count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            chk({tag, "_kind"}, obs_q[i].kind, exp_q[i].kind);
            if (exp_q[i].kind == 0) chk({tag, "_char"}, obs_q[i].ch, exp_q[i].ch);
            if (exp_q[i].at >= 0)   chk({tag, "_time"}, obs_q[i].at, exp_q[i].at);
        end
        obs_q.delete();
        exp_q.delete();
        chk({tag, "_hold"}, int'(ascii_out), last_ch);
    endtask

    initial begin
        int c0;
        int nl;
        string code;

        // Reset state
        rst = 1'b1;
        tick(3);
        chk("rst_ascii", int'(ascii_out), 0);
        chk("rst_valid", int'(ascii_valid), 0);
        chk("rst_error", int'(error), 0);
        rst = 1'b0;
        quiet(10);
        obs_q.delete();

        // 'A' with exact letter and space timing
        mark(10); quiet(10); mark(30);
        c0 = cyc;
        quiet(70);
        expect_ev(0, 8'h41, c0 + 22);
        expect_ev(0, 32, c0 + 52);
        last_ch = 32;
        check_events("A");

        // '5' then '0' (five-element digits)
        for (int i = 0; i < 5; i++) begin
            mark(10);
            if (i < 4) quiet(10);
        end
        quiet(30);
        expect_ev(0, 8'h35, -1);
        for (int i = 0; i < 5; i++) begin
            mark(30);
            if (i < 4) quiet(10);
        end
        quiet(70);
        expect_ev(0, 8'h30, -1);
        expect_ev(0, 32, -1);
        last_ch = 32;
        check_events("digits");

        // Six dots: overflow -> error, ascii_out held
        for (int i = 0; i < 6; i++) begin
            mark(10);
            if (i < 5) quiet(10);
        end
        c0 = cyc;
        quiet(70);
        expect_ev(1, 0, c0 + 22);
        expect_ev(0, 32, c0 + 52);
        check_events("overflow");

        // 'E' followed by long silence: one letter, one space, nothing more
        mark(10);
        c0 = cyc;
        quiet(80);
        quiet(40);
        expect_ev(0, 8'h45, c0 + 22);
        expect_ev(0, 32, c0 + 52);
        last_ch = 32;
        check_events("E_space");

        // Glitch inside a letter gap: gap time keeps accumulating
        mark(30); quiet(8); mark(2);
        c0 = cyc;
        quiet(70);
        expect_ev(0, 8'h54, c0 + 14);
        expect_ev(0, 32, c0 + 44);
        last_ch = 32;
        check_events("glitch_T");

        // Reset in the middle of the second mark of 'A'
        mark(10); quiet(10);
        key_in = 1'b1;
        tick(5);
        rst = 1'b1;
        tick(2);
        chk("midrst_ascii", int'(ascii_out), 0);
        chk("midrst_valid", int'(ascii_valid), 0);
        chk("midrst_error", int'(error), 0);
        rst = 1'b0;
        tick(8);
        key_in = 1'b0;
        quiet(40);
        last_ch = 0;
        check_events("midrst_quiet");
        mark(30); quiet(10); mark(10);
        quiet(70);
        expect_ev(0, 8'h4E, -1);
        expect_ev(0, 32, -1);
        last_ch = 32;
        check_events("N_after_rst");

        // Random words checked against the table model
        for (int w = 0; w < 8; w++) begin
            nl = $urandom_range(1, 4);
            for (int l = 0; l < nl; l++) begin
                code = rand_code();
                send_code(code);
                if (l < nl - 1) quiet($urandom_range(24, 45));
                else            quiet($urandom_range(56, 70));
            end
            expect_ev(0, 32, -1);
            last_ch = 32;
            check_events("rand_word");
        end

        chk("valid_error_overlap", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
